ysyx_22050854_lsu: RTL
======================

# ysyx_22050854_lsu

Multi-cycle load/store unit between the ALU result (effective address) and register writeback. It replaces direct combinational memory reads with a registered request/grant/response handshake to the data memory port. It generates the 8-byte-aligned bus address, the byte strobes and the shifted store data. On loads it extracts, sign-extends or zero-extends the addressed bytes and holds them for writeback. The core stalls PC update while `lsu_ready` is low.

## Interface
- `ADDR_W`, 64: address width
- `MMIO_BASE`, 64'h8000_0000: lowest address that reaches memory
- `clk` input 1: clock, all state on rising edge
- `rst` input 1: asynchronous, active-low reset
- `lsu_valid` input 1: access request, qualified by `MemRd`/`MemWr`
- `MemRd` input 1: load
- `MemWr` input 1: store
- `MemOP` input 3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
- `addr` input 64: effective address
- `wdata` input 64: store data, LSB-justified
- `lsu_ready` output 1: idle, can accept
- `resp_valid` output 1: one-cycle completion pulse
- `resp_rdata` output 64: extended load data, held until next accept
- `resp_err` output 1: misaligned or illegal access, valid with `resp_valid`
- `mem_req` output 1: bus request
- `mem_wen` output 1: store when 1
- `mem_addr` output 64: `{addr[63:3],3'b000}`
- `mem_wdata` output 64: `wdata << (8*addr[2:0])`
- `mem_wmask` output 8: byte strobes
- `mem_gnt` input 1: request accepted this cycle
- `mem_rvalid` input 1: read data valid
- `mem_rdata` input 64: aligned 8-byte read data

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: `lsu_ready`=1. If `lsu_valid` & (`MemRd`|`MemWr`), capture `addr`, `MemOP`, direction and `wdata`. Then:
  - Both `MemRd` and `MemWr` set, or MemOP 111: error. Go to DONE with `resp_err`=1 and no bus access.
  - `addr` < `MMIO_BASE`: go to DONE with no bus access. Load data is 0 and `resp_err`=0.
  - Otherwise: go to REQ.
- REQ: `mem_req`=1 with stable address, data and mask. On `mem_gnt`, a store goes to DONE and a load goes to WAIT.
- WAIT: on `mem_rvalid`, register the extracted data and go to DONE. `mem_rvalid` is ignored in every other state.
- DONE: `resp_valid`=1 for exactly one cycle, then go to IDLE. `lsu_valid` is ignored outside IDLE.
- Byte strobes: `mem_wmask` = {b:8'h01, h:8'h03, w:8'h0F, d:8'hFF} << `addr[2:0]`, truncated to 8 bits. The mask is 0 for loads.
- Load extract:
  - `sh = mem_rdata >> (8*addr[2:0])`.
  - Take the low 1, 2, 4 or 8 bytes per MemOP.
  - Signed forms replicate the top extracted bit. The u forms zero-fill.

## Timing
- Reset values: state IDLE, `lsu_ready`=1, `mem_req`=0, `mem_wen`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wmask`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- All `mem_*` and `resp_*` outputs are registered. `lsu_ready` is decoded from state.
- Store with zero-wait grant: accept at edge 0, `mem_req` in cycle 1, `resp_valid` in cycle 2.
- Load with zero-wait grant and `mem_rvalid` one cycle after grant: `resp_valid` in cycle 3.
- Short-circuit (below base or error): `resp_valid` in cycle 1.
- `mem_req` stays asserted, with fields stable, until `mem_gnt`. There is no timeout.
- Reset asserted mid-transaction: IDLE and `mem_req`=0 immediately. A late `mem_rvalid` is then ignored.
- Back-to-back accesses: a new request can be accepted in the cycle after `resp_valid`.

## Configuration
- `YSYX_22050854_LSU_MISALIGN_CHK_EN` defined:
  - h/hu needs `addr[0]`=0. w/wu needs `addr[1:0]`=0. d needs `addr[2:0]`=0.
  - Violations short-circuit to DONE with `resp_err`=1, `resp_rdata`=0 and no bus access.
- Undefined:
  - Misaligned accesses are issued.
  - Strobes and store data above byte 7 are truncated.
  - Load bytes beyond the dword read as 0 before extension.

## Structure
- Shared package `ysyx_22050854_lsu_pkg` holds:
  - the MemOP encoding constants;
  - the FSM state enum;
  - `MMIO_BASE`.
- One sub-module, `ysyx_22050854_load_ext`: combinational shift plus sign/zero extension of `mem_rdata` by `addr[2:0]` and MemOP.

## Test plan
- sb: `addr`=0x8000_0003, `wdata`=0xAB → `mem_addr`=0x8000_0000, `mem_wmask`=8'h08, `mem_wdata`=0xAB00_0000; `resp_valid` in cycle 2.
- lb: `addr`=0x8000_0005, `mem_rdata`=0x0000_8000_0000_0000 → `resp_rdata`=0xFFFF_FFFF_FFFF_FF80. Same access as lbu → 0x80.
- lw: `mem_gnt` delayed 3 cycles and `mem_rvalid` 2 cycles after grant → `mem_req` held 4 cycles with stable fields; exactly one `resp_valid`.
- Load at `addr`=0x1000 → no `mem_req`; `resp_valid` in cycle 1; `resp_rdata`=0.
- With the macro defined, lw at 0x8000_0002 → `resp_err`=1, no `mem_req`. Without the macro → load issued; `mem_rdata`=0x1122_3344_5566_7788 gives 0x3344_5566.
- `rst` asserted while in WAIT, then `mem_rvalid` pulsed → outputs at reset values; no `resp_valid`; next request processes normally.

Source files
------------

// File: rtl/ysyx_22050854_lsu_pkg.sv
// rtl/ysyx_22050854_lsu_pkg.sv - shared MemOP encoding, FSM states and memory base for the LSU
package ysyx_22050854_lsu_pkg;

  localparam logic [63:0] MMIO_BASE = 64'h8000_0000;

  localparam logic [2:0] OP_B   = 3'b000;
  localparam logic [2:0] OP_H   = 3'b001;
  localparam logic [2:0] OP_W   = 3'b010;
  localparam logic [2:0] OP_D   = 3'b011;
  localparam logic [2:0] OP_BU  = 3'b100;
  localparam logic [2:0] OP_HU  = 3'b101;
  localparam logic [2:0] OP_WU  = 3'b110;
  localparam logic [2:0] OP_BAD = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_e;

  // Unshifted byte strobes for an access size (MemOP[1:0]).
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      2'b10:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22050854_load_ext.sv
// rtl/ysyx_22050854_load_ext.sv - shift aligned read data by byte offset and sign/zero extend per MemOP
module ysyx_22050854_load_ext
  import ysyx_22050854_lsu_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [2:0]  op,
  output logic [63:0] data
);

  logic [63:0] sh;

  // Bytes shifted past the top of the dword come in as zero before extension.
  always_comb begin
    sh   = rdata >> {off, 3'b000};
    data = sh;
    case (op)
      OP_B:    data = {{56{sh[7]}}, sh[7:0]};
      OP_BU:   data = {56'h0, sh[7:0]};
      OP_H:    data = {{48{sh[15]}}, sh[15:0]};
      OP_HU:   data = {48'h0, sh[15:0]};
      OP_W:    data = {{32{sh[31]}}, sh[31:0]};
      OP_WU:   data = {32'h0, sh[31:0]};
      default: data = sh;
    endcase
  end

endmodule

// File: rtl/ysyx_22050854_lsu.sv
// rtl/ysyx_22050854_lsu.sv - multi-cycle load/store unit; YSYX_22050854_LSU_MISALIGN_CHK_EN enables alignment errors
module ysyx_22050854_lsu #(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] MMIO_BASE = ysyx_22050854_lsu_pkg::MMIO_BASE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_valid,
  input  logic              MemRd,
  input  logic              MemWr,
  input  logic [2:0]        MemOP,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic              lsu_ready,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata
);
  import ysyx_22050854_lsu_pkg::*;

  lsu_state_e  state;
  logic [2:0]  off_q;
  logic [2:0]  op_q;
  logic        bad_req;
  logic        misalign;
  logic        below_base;
  logic [15:0] mask_wide;
  logic [63:0] ext_data;

  assign lsu_ready = (state == S_IDLE);

  always_comb begin
    bad_req = (MemRd & MemWr) | (MemOP == OP_BAD);
`ifdef YSYX_22050854_LSU_MISALIGN_CHK_EN
    case (MemOP[1:0])
      2'b01:   misalign = addr[0];
      2'b10:   misalign = |addr[1:0];
      2'b11:   misalign = |addr[2:0];
      default: misalign = 1'b0;
    endcase
`else
    misalign = 1'b0;
`endif
    below_base = (addr < MMIO_BASE);
    // Upper half discards strobes of a misaligned access that run past byte 7.
    mask_wide  = {8'h00, size_mask(MemOP[1:0])} << addr[2:0];
  end

  ysyx_22050854_load_ext u_load_ext (
    .rdata (mem_rdata),
    .off   (off_q),
    .op    (op_q),
    .data  (ext_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      off_q      <= 3'b000;
      op_q       <= 3'b000;
      mem_req    <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 64'h0;
      mem_wmask  <= 8'h00;
      resp_valid <= 1'b0;
      resp_rdata <= 64'h0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (lsu_valid & (MemRd | MemWr)) begin
            off_q      <= addr[2:0];
            op_q       <= MemOP;
            resp_rdata <= 64'h0;
            if (bad_req | misalign) begin
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= S_DONE;
            end else if (below_base) begin
              resp_err   <= 1'b0;
              resp_valid <= 1'b1;
              state      <= S_DONE;
            end else begin
              resp_err  <= 1'b0;
              mem_req   <= 1'b1;
              mem_wen   <= MemWr;
              mem_addr  <= {addr[ADDR_W-1:3], 3'b000};
              mem_wdata <= wdata << {addr[2:0], 3'b000};
              mem_wmask <= MemWr ? mask_wide[7:0] : 8'h00;
              state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_wen) begin
              resp_valid <= 1'b1;
              state      <= S_DONE;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            resp_rdata <= ext_data;
            resp_valid <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
